cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_seq_decode.sv | 51 +++++
 rtl/cpu_sequencer.sv | 138 +++++++++++++
 tb/tb_cpu_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcode constants, the sequencing
// state encoding and the register-file write-data select encodings.
package cpu_pkg;

  // Opcodes, ir[7:5]. JNZ and CMP share an encoding; dest==3 selects the jump.
  localparam logic [2:0] OpJmp = 3'b011;
  localparam logic [2:0] OpJz  = 3'b100;
  localparam logic [2:0] OpMov = 3'b101;
  localparam logic [2:0] OpJnz = 3'b110;
  localparam logic [2:0] OpCmp = 3'b110;

  // Destination field value that marks the jump class.
  localparam logic [1:0] DestJump = 2'd3;

  // Register-file write-data source.
  localparam logic [1:0] WselAlu = 2'b00;
  localparam logic [1:0] WselReg = 2'b01;
  localparam logic [1:0] WselImm = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction-class decode for the CPU sequencer.
// Ports:
//   ir          in  latched instruction (opcode ir[7:5], dest ir[4:3], src ir[2:0])
//   zflag       in  registered zero flag, used for conditional jumps
//   is_jump     out instruction is JMP/JZ/JNZ
//   take_jump   out jump is taken (pc loads target)
//   writes_rf   out instruction writes the register file in WB
//   loads_zflag out zero flag is loaded from the ALU in EXEC
//   wdata_sel   out write-data source for this instruction
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       zflag,
  output logic       is_jump,
  output logic       take_jump,
  output logic       writes_rf,
  output logic       loads_zflag,
  output logic [1:0] wdata_sel
);

  logic [2:0] opcode;
  logic [1:0] dest;
  logic [2:0] src;

  assign opcode = ir[7:5];
  assign dest   = ir[4:3];
  assign src    = ir[2:0];

  always_comb begin
    is_jump     = 1'b0;
    take_jump   = 1'b0;
    writes_rf   = 1'b0;
    loads_zflag = 1'b0;
    wdata_sel   = WselAlu;

    if (dest == DestJump && (opcode == OpJmp || opcode == OpJz || opcode == OpJnz)) begin
      is_jump   = 1'b1;
      take_jump = (opcode == OpJmp) || (opcode == OpJz && zflag) ||
                  (opcode == OpJnz && !zflag);
    end else begin
      writes_rf   = (opcode != OpCmp);
      loads_zflag = (opcode != OpMov);
      if (opcode == OpMov) begin
        // src>=4 encodes an immediate; lower values name a source register.
        wdata_sel = src[2] ? WselImm : WselReg;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Four-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB.
// Optional feature: define CPU_SEQ_STEP_EN to allow single-stepping from HALT.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   instr           instruction-memory data at pc
//   alu_zero        ALU zero result, sampled into zflag in EXEC
//   run, halt_req   level controls; halting takes effect only at the WB boundary
//   step            one-cycle pulse, runs one instruction while halted
//   pc, ir          instruction address and latched instruction
//   rf_we, rf_waddr register-file write strobe (WB only) and address
//   wdata_sel, imm  write-data source and MOV immediate
//   zflag, halted   registered zero flag, high while in HALT
//   retired         wrapping count of completed instructions
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               alu_zero,
  input  logic               run,
  input  logic               halt_req,
  input  logic               step,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               rf_we,
  output logic [2:0]         rf_waddr,
  output logic [1:0]         wdata_sel,
  output logic [7:0]         imm,
  output logic               zflag,
  output logic               halted,
  output logic [7:0]         retired
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               zflag_q;
  logic [7:0]         retired_q;
  logic               stop_at_wb;

  logic       is_jump;
  logic       take_jump;
  logic       writes_rf;
  logic       loads_zflag;
  logic [1:0] dec_wsel;

  cpu_seq_decode u_decode (
    .ir          (ir_q[7:0]),
    .zflag       (zflag_q),
    .is_jump     (is_jump),
    .take_jump   (take_jump),
    .writes_rf   (writes_rf),
    .loads_zflag (loads_zflag),
    .wdata_sel   (dec_wsel)
  );

`ifdef CPU_SEQ_STEP_EN
  // Set while a single-stepped instruction is in flight; forces a return to HALT.
  logic step_mode_q, step_mode_d;
  assign stop_at_wb = step_mode_q || halt_req || !run;
`else
  logic unused_step;
  assign unused_step = step;
  assign stop_at_wb  = halt_req || !run;
`endif

  always_comb begin
    state_d = state_q;
`ifdef CPU_SEQ_STEP_EN
    step_mode_d = step_mode_q;
`endif
    unique case (state_q)
      StIdle:   if (run && !halt_req) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb: begin
        state_d = stop_at_wb ? StHalt : StFetch;
`ifdef CPU_SEQ_STEP_EN
        step_mode_d = 1'b0;
`endif
      end
      StHalt: begin
`ifdef CPU_SEQ_STEP_EN
        if (step) begin
          state_d     = StFetch;
          step_mode_d = 1'b1;
        end else if (run && !halt_req) begin
          state_d = StFetch;
        end
`else
        if (run && !halt_req) state_d = StFetch;
`endif
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      zflag_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch) ir_q <= instr;
      if (state_q == StExec && loads_zflag) zflag_q <= alu_zero;
      if (state_q == StWb) begin
        pc_q      <= take_jump ? PC_W'({1'b0, ir_q[2:0]}) : pc_q + PC_W'(1);
        retired_q <= retired_q + 8'd1;
      end
    end
  end

`ifdef CPU_SEQ_STEP_EN
  always_ff @(posedge clk) begin
    if (reset) step_mode_q <= 1'b0;
    else       step_mode_q <= step_mode_d;
  end
`endif

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign zflag     = zflag_q;
  assign retired   = retired_q;
  assign halted    = (state_q == StHalt);
  assign rf_we     = (state_q == StWb) && writes_rf;
  assign wdata_sel = (state_q == StWb) ? dec_wsel : WselAlu;
  assign rf_waddr  = {1'b0, ir_q[4:3]};
  assign imm       = {5'b0, ir_q[2:0] - 3'd4};

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed program with a reference
// model that queues expected per-instruction results, compared at WB.
module tb_cpu_sequencer;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;

  logic               clk = 1'b0;
  logic               reset, run, halt_req, step, alu_zero;
  logic [INSTR_W-1:0] instr, ir;
  logic [PC_W-1:0]    pc;
  logic               rf_we, zflag, halted;
  logic [2:0]         rf_waddr;
  logic [1:0]         wdata_sel;
  logic [7:0]         imm, retired;

  logic [7:0] rom [16];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       we;
    logic [1:0] wsel;
    logic [7:0] imm;
    logic [2:0] waddr;
    logic [3:0] pc;
    logic       z;
    logic [7:0] ret;
  } exp_t;

  exp_t exp_q[$];

  // Reference architectural state.
  logic [3:0] m_pc  = '0;
  logic       m_z   = 1'b0;
  logic [7:0] m_ret = '0;

  always #5 clk = ~clk;

  assign instr = rom[pc];

  cpu_sequencer #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .run       (run),
    .halt_req  (halt_req),
    .step      (step),
    .pc        (pc),
    .ir        (ir),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .wdata_sel (wdata_sel),
    .imm       (imm),
    .zflag     (zflag),
    .halted    (halted),
    .retired   (retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model one instruction at m_pc with the given ALU zero result.
  task automatic push_expect(input logic az);
    exp_t       e;
    logic [7:0] i;
    logic [2:0] op, s;
    logic [1:0] d;
    logic       jmp, take;
    i    = rom[m_pc];
    op   = i[7:5];
    d    = i[4:3];
    s    = i[2:0];
    jmp  = (d == 2'd3) && (op == 3'b011 || op == 3'b100 || op == 3'b110);
    if (!jmp && op != 3'b101) m_z = az;
    take = jmp && (op == 3'b011 || (op == 3'b100 && m_z) || (op == 3'b110 && !m_z));
    e.we    = !jmp && op != 3'b110;
    e.wsel  = (e.we && op == 3'b101) ? ((s >= 3'd4) ? 2'b10 : 2'b01) : 2'b00;
    e.imm   = {5'b0, s - 3'd4};
    e.waddr = {1'b0, d};
    m_pc    = take ? {1'b0, s} : m_pc + 4'd1;
    m_ret   = m_ret + 8'd1;
    e.pc    = m_pc;
    e.z     = m_z;
    e.ret   = m_ret;
    exp_q.push_back(e);
  endtask

  // Entered with the DUT in FETCH; leaves it one cycle after WB.
  task automatic run_instr(input logic az, input bit halt_mid);
    exp_t       e;
    logic [7:0] exp_ir;
    exp_ir = rom[m_pc];
    push_expect(az);
    alu_zero = az;
    check("fetch_we", rf_we, 1'b0);
    tick();
    check("decode_ir", ir, exp_ir);
    check("decode_we", rf_we, 1'b0);
    if (halt_mid) halt_req = 1'b1;
    tick();
    check("exec_we", rf_we, 1'b0);
    tick();
    e = exp_q.pop_front();
    check("wb_we", rf_we, e.we);
    check("wb_wsel", wdata_sel, e.wsel);
    check("wb_waddr", rf_waddr, e.waddr);
    check("wb_imm", imm, e.imm);
    check("wb_zflag", zflag, e.z);
    tick();
    check("pc", pc, e.pc);
    check("retired", retired, e.ret);
    check("halted", halted, halt_mid);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 16; i++) rom[i] = 8'h20;
    rom[0] = 8'hB6;  // MOV, src=6 -> immediate 2
    rom[1] = 8'h20;  // ALU op, dest 0
    rom[2] = 8'h4B;  // ALU op, dest 1
    rom[3] = 8'h7D;  // JMP 5
    rom[5] = 8'hC0;  // CMP
    rom[6] = 8'h9A;  // JZ 2

    reset = 1'b1; run = 1'b0; halt_req = 1'b0; step = 1'b0; alu_zero = 1'b0;
    tick();
    tick();
    check("rst_pc", pc, 4'd0);
    check("rst_ir", ir, 8'h00);
    check("rst_zflag", zflag, 1'b0);
    check("rst_retired", retired, 8'd0);
    check("rst_we", rf_we, 1'b0);
    check("rst_wsel", wdata_sel, 2'b00);
    check("rst_halted", halted, 1'b0);

    reset = 1'b0;
    tick();
    check("idle_pc", pc, 4'd0);
    run = 1'b1;
    tick();

    // MOV immediate
    run_instr(1'b0, 1'b0);
    check("mov_pc", pc, 4'd1);
    check("mov_retired", retired, 8'd1);
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    // JMP 5
    run_instr(1'b0, 1'b0);
    check("jmp_pc", pc, 4'd5);
    // CMP zero, JZ taken
    run_instr(1'b1, 1'b0);
    run_instr(1'b0, 1'b0);
    check("jz_taken_pc", pc, 4'd2);
    // CMP nonzero, JZ not taken
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b0);
    check("jz_fall_pc", pc, 4'd7);
    // pc 7..15 then wrap
    for (int k = 0; k < 9; k++) run_instr(1'b1, 1'b0);
    check("wrap_pc", pc, 4'd0);
    run_instr(1'b1, 1'b0);
    // halt_req raised in DECODE: instruction completes, then HALT
    run_instr(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_pc", pc, m_pc);
      check("halt_halted", halted, 1'b1);
      check("halt_we", rf_we, 1'b0);
    end

`ifdef CPU_SEQ_STEP_EN
    push_expect(1'b1);
    alu_zero = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_halted", halted, 1'b0);
    tick();
    tick();
    tick();
    e = exp_q.pop_front();
    check("step_we", rf_we, e.we);
    tick();
    check("step_back_halted", halted, 1'b1);
    check("step_retired", retired, e.ret);
    check("step_pc", pc, e.pc);
    tick();
    check("step_stay_halted", halted, 1'b1);
`else
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("nostep_halted", halted, 1'b1);
      check("nostep_we", rf_we, 1'b0);
      tick();
    end
    check("nostep_retired", retired, m_ret);
    check("nostep_pc", pc, m_pc);
`endif

    // Resume, then reset in EXEC
    halt_req = 1'b0;
    tick();
    check("resume_halted", halted, 1'b0);
    tick();
    tick();
    check("exec_we_pre_rst", rf_we, 1'b0);
    check("exec_zflag_pre_rst", zflag, m_z);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run   = 1'b0;
    check("exec_rst_pc", pc, 4'd0);
    check("exec_rst_zflag", zflag, 1'b0);
    check("exec_rst_retired", retired, 8'd0);
    check("exec_rst_ir", ir, 8'h00);
    check("exec_rst_halted", halted, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_we", rf_we, 1'b0);
      check("post_rst_pc", pc, 4'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
